spi_pwm_bank: RTL and testbench

Parametrised SPI-controlled PWM bank: `CHANNELS` outputs with `WIDTH`-bit levels and a programmable period, prescaler and per-channel output inversion. Levels are double-buffered, so a PWM period never glitches mid-cycle. Supports burst read/write with address auto-increment. It is the next-generation PWM/SPI peripheral for the tile, driven from an external MCU over a mode-0 SPI link sampled in the `clk` domain.

---
 rtl/spi_pwm_bank.sv | 195 +++++++++++++++++++
 tb/tb_spi_pwm_bank.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pwm_bank.sv
// SPI-controlled bank of PWM outputs. Levels and period are double-buffered so
// a running PWM period never changes shape; inversion takes effect at once.
`timescale 1ns/1ps
module spi_pwm_bank #(
    parameter int CHANNELS = 7,
    parameter int WIDTH    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sclk,
    input  logic                cs,
    input  logic                mosi,
    output logic                miso,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    localparam logic [6:0]       ADDR_P   = 7'h70;
    localparam logic [6:0]       ADDR_PS  = 7'h71;
    localparam logic [6:0]       ADDR_INV = 7'h72;
    localparam logic [WIDTH-1:0] P_RST    = {{(WIDTH-1){1'b1}}, 1'b0};

    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_p0, cs_p1;
    logic mosi_p0, mosi_p1;

    logic        sclk_rise, sclk_fall, cs_act;
    logic [14:0] in_buf;
    logic [15:0] shift_in;
    logic [15:0] out_buf;
    logic [3:0]  bit_cnt;
    logic        cmd_done, wr_mode;
    logic        load_first, load_next;
    logic [6:0]  addr, rd_addr;
    logic [15:0] rd_data;
    logic        wr_en;
    logic        unused_bits;

    logic [WIDTH-1:0]    lvl     [CHANNELS];
    logic [WIDTH-1:0]    lvl_act [CHANNELS];
    logic [WIDTH-1:0]    period_sh, period_act, cnt;
    logic [7:0]          prescale, ps_cnt;
    logic [CHANNELS-1:0] inv;
    logic                tick, wrap;

    // Stage p0/p1: two-flop synchronisers; p2 holds previous sclk for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= cs;
            cs_p1   <= cs_p0;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    assign sclk_rise   = sclk_p1 & ~sclk_p2;
    assign sclk_fall   = ~sclk_p1 & sclk_p2;
    assign cs_act      = ~cs_p1;
    assign shift_in    = {in_buf, mosi_p1};
    assign wr_en       = cs_act & sclk_rise & cmd_done & wr_mode & (bit_cnt == 4'd15);
    assign miso        = out_buf[15];
    assign unused_bits = ^shift_in;

    // Frame decoder: command byte, then 16-bit words with address auto-increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_buf     <= '0;
            out_buf    <= '0;
            bit_cnt    <= '0;
            cmd_done   <= 1'b0;
            wr_mode    <= 1'b0;
            load_first <= 1'b0;
            load_next  <= 1'b0;
            addr       <= '0;
        end else if (!cs_act) begin
            in_buf     <= '0;
            out_buf    <= '0;
            bit_cnt    <= '0;
            cmd_done   <= 1'b0;
            wr_mode    <= 1'b0;
            load_first <= 1'b0;
            load_next  <= 1'b0;
            addr       <= '0;
        end else begin
            if (sclk_rise) begin
                in_buf  <= shift_in[14:0];
                bit_cnt <= bit_cnt + 4'd1;
                if (!cmd_done) begin
                    if (bit_cnt == 4'd7) begin
                        cmd_done   <= 1'b1;
                        wr_mode    <= shift_in[7];
                        addr       <= shift_in[6:0];
                        load_first <= ~shift_in[7];
                        bit_cnt    <= '0;
                    end
                end else if (bit_cnt == 4'd15) begin
                    bit_cnt <= '0;
                    if (wr_mode)
                        addr <= addr + 7'd1;
                    else
                        load_next <= 1'b1;
                end
            end
            if (sclk_fall) begin
                if (load_first) begin
                    out_buf    <= rd_data;
                    load_first <= 1'b0;
                end else if (load_next) begin
                    out_buf   <= rd_data;
                    addr      <= rd_addr;
                    load_next <= 1'b0;
                end else begin
                    out_buf <= {out_buf[14:0], 1'b0};
                end
            end
        end
    end

    // The first load after the command reads addr itself; later loads read the next one
    always_comb begin
        rd_addr = load_first ? addr : addr + 7'd1;
        rd_data = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (rd_addr == 7'(i))
                rd_data = 16'(lvl[i]);
        if (rd_addr == ADDR_P)   rd_data = 16'(period_sh);
        if (rd_addr == ADDR_PS)  rd_data = 16'(prescale);
        if (rd_addr == ADDR_INV) rd_data = 16'(inv);
    end

    // Shadow registers, written at word completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++)
                lvl[i] <= '0;
            period_sh <= P_RST;
            prescale  <= '0;
            inv       <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < CHANNELS; i++)
                if (addr == 7'(i))
                    lvl[i] <= shift_in[WIDTH-1:0];
            if (addr == ADDR_P)   period_sh <= shift_in[WIDTH-1:0];
            if (addr == ADDR_PS)  prescale  <= shift_in[7:0];
            if (addr == ADDR_INV) inv       <= shift_in[CHANNELS-1:0];
        end
    end

    assign tick = (ps_cnt == prescale);
    assign wrap = tick & (cnt == period_act);

    // Prescaler and period counter; active copies refresh only on wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_cnt       <= '0;
            cnt          <= '0;
            period_act   <= P_RST;
            period_start <= 1'b0;
            for (int i = 0; i < CHANNELS; i++)
                lvl_act[i] <= '0;
        end else begin
            period_start <= wrap;
            if ((wr_en && addr == ADDR_PS) || tick)
                ps_cnt <= '0;
            else
                ps_cnt <= ps_cnt + 8'd1;
            if (wrap) begin
                cnt        <= '0;
                period_act <= period_sh;
                for (int i = 0; i < CHANNELS; i++)
                    lvl_act[i] <= lvl[i];
            end else if (tick) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        pwm_out = '0;
        for (int i = 0; i < CHANNELS; i++)
            pwm_out[i] = (cnt < lvl_act[i]) ^ inv[i];
    end

endmodule

// File: tb/tb_spi_pwm_bank.sv
// Directed bench for spi_pwm_bank: SPI register access, PWM timing, invert,
// frame abort, unmapped addresses and asynchronous reset.
`timescale 1ns/1ps
module tb_spi_pwm_bank;

    localparam int CHANNELS = 7;
    localparam int WIDTH    = 8;

    logic                clk = 1'b0;
    logic                reset, sclk, cs, mosi;
    logic                miso, period_start;
    logic [CHANNELS-1:0] pwm_out;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_pwm_bank #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso), .pwm_out(pwm_out), .period_start(period_start)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        wait_clk(6);
        r = miso;
        sclk = 1'b1;
        wait_clk(6);
        sclk = 1'b0;
        wait_clk(6);
    endtask

    task automatic spi_begin();
        cs = 1'b0;
        wait_clk(6);
    endtask

    task automatic spi_end();
        cs   = 1'b1;
        mosi = 1'b0;
        wait_clk(8);
    endtask

    task automatic spi_cmd(input logic [7:0] c);
        logic r;
        for (int i = 7; i >= 0; i--)
            spi_bit(c[i], r);
    endtask

    task automatic spi_word(input logic [15:0] w, output logic [15:0] d);
        logic r;
        d = '0;
        for (int i = 15; i >= 0; i--) begin
            spi_bit(w[i], r);
            d = {d[14:0], r};
        end
    endtask

    task automatic write_reg(input logic [6:0] a, input logic [15:0] w);
        logic [15:0] d;
        spi_begin();
        spi_cmd({1'b1, a});
        spi_word(w, d);
        spi_end();
    endtask

    task automatic read_reg(input logic [6:0] a, output logic [15:0] d);
        spi_begin();
        spi_cmd({1'b0, a});
        spi_word(16'h0000, d);
        spi_end();
    endtask

    // Advances at least one cycle, then waits for the next period_start pulse
    task automatic wait_period(input string tag, input int limit, output int n);
        @(negedge clk);
        n = 1;
        while (!period_start && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, period_start}, 32'd1);
    endtask

    task automatic count_high(input int ch, input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            if (pwm_out[ch]) c++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          n, c;
        logic        r;
        logic [15:0] d;

        reset = 1'b1;
        sclk  = 1'b0;
        cs    = 1'b1;
        mosi  = 1'b0;
        wait_clk(3);
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_pstart", {31'd0, period_start}, 32'd0);

        reset = 1'b0;
        wait_period("rst_wrap1_seen", 400, n);
        check("rst_first_period", n, 255);
        wait_period("rst_wrap2_seen", 400, n);
        check("rst_period", n, 255);

        // Single write; aligned to a wrap so the next wrap falls after the write
        write_reg(7'h02, 16'h0040);
        c = 0;
        n = 0;
        while (!period_start && n < 300) begin
            if (pwm_out[2]) c++;
            @(negedge clk);
            n++;
        end
        check("single_before_wrap", c, 0);
        check("single_wrap_seen", {31'd0, period_start}, 32'd1);
        count_high(2, 255, c);
        check("single_duty", c, 64);
        check("single_next_wrap", {31'd0, period_start}, 32'd1);
        read_reg(7'h02, d);
        check("single_read", 32'(d), 32'h0040);

        // Burst write from 0, burst read back (fourth word is an unwritten level)
        spi_begin();
        spi_cmd(8'h80);
        spi_word(16'd10, d);
        spi_word(16'd20, d);
        spi_word(16'd30, d);
        spi_end();
        spi_begin();
        spi_cmd(8'h00);
        spi_word(16'h0000, d);
        check("burst_rd0", 32'(d), 32'd10);
        spi_word(16'h0000, d);
        check("burst_rd1", 32'(d), 32'd20);
        spi_word(16'h0000, d);
        check("burst_rd2", 32'(d), 32'd30);
        spi_word(16'h0000, d);
        check("burst_rd3", 32'(d), 32'd0);
        spi_end();

        // Period 10 ticks, tick every 4 clk, level 5 -> 20 high / 20 low
        write_reg(7'h70, 16'd9);
        write_reg(7'h71, 16'd3);
        write_reg(7'h01, 16'd5);
        wait_period("pp_wrap_seen", 3000, n);
        count_high(1, 40, c);
        check("pp_duty", c, 20);
        check("pp_period_40", {31'd0, period_start}, 32'd1);

        write_reg(7'h01, 16'd200);
        wait_period("full_wrap_seen", 200, n);
        count_high(1, 40, c);
        check("full_on", c, 40);

        // Invert with level 0
        write_reg(7'h00, 16'd0);
        wait_period("zero_wrap_seen", 200, n);
        count_high(0, 40, c);
        check("zero_off", c, 0);
        write_reg(7'h72, 16'h0001);
        count_high(0, 40, c);
        check("inv_on", c, 40);

        // Aborted write after 20 bits leaves L1 alone
        spi_begin();
        spi_cmd(8'h81);
        for (int i = 0; i < 12; i++)
            spi_bit(1'b1, r);
        spi_end();
        read_reg(7'h01, d);
        check("abort_keep", 32'(d), 32'h00C8);

        write_reg(7'h50, 16'h1234);
        read_reg(7'h50, d);
        check("unmapped_read", 32'(d), 32'h0000);
        read_reg(7'h70, d);
        check("read_period", 32'(d), 32'h0009);
        read_reg(7'h71, d);
        check("read_prescale", 32'(d), 32'h0003);
        read_reg(7'h72, d);
        check("read_inv", 32'(d), 32'h0001);

        // Reset in the middle of a read frame with miso and outputs high
        spi_begin();
        spi_cmd(8'h01);
        for (int i = 0; i < 8; i++)
            spi_bit(1'b0, r);
        check("mid_miso", {31'd0, miso}, 32'd1);
        check("mid_pwm", 32'(pwm_out[1:0]), 32'd3);
        reset = 1'b1;
        #1;
        check("async_rst_pwm", 32'(pwm_out), 32'd0);
        check("async_rst_miso", {31'd0, miso}, 32'd0);
        check("async_rst_pstart", {31'd0, period_start}, 32'd0);
        cs = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_period("post_rst_wrap_seen", 400, n);
        check("post_rst_period", n, 255);
        read_reg(7'h00, d);
        check("post_rst_l0", 32'(d), 32'd0);
        read_reg(7'h70, d);
        check("post_rst_p", 32'(d), 32'h00FE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
